// File: rtl/vga_color_encoder.sv
// vga_color_encoder
//
// Converts a 24-bit RGB pixel stream into 8-bit RGB332 codes through a
// two-stage valid/ready pipeline.
//   S1 holds the pre-processed pixel (dithered and clamped when enabled).
//   S2 holds the quantized code and drives the outputs directly.
// Latency is two cycles from input acceptance to out_valid when out_ready
// stays high. Throughput is one pixel per cycle.
//
// Optional feature: define VGA_COLOR_ENCODER_DITHER_EN to enable 4x4
// ordered (Bayer) dithering. Dithering uses the column and row counters.
// With the macro undefined, channels pass through S1 unchanged.
//
// Ports
//   clk        in   sole clock; all state updates on the rising edge
//   reset      in   asynchronous active-high reset
//   in_color   in   [23:0] pixel {R[23:16], G[15:8], B[7:0]}
//   in_valid   in   in_color / in_sof / in_eol are valid
//   in_ready   out  encoder accepts input this cycle
//   in_sof     in   pixel is the first pixel of a frame
//   in_eol     in   pixel is the last pixel of a line
//   out_code   out  [7:0] RGB332 code {R3, G3, B2}
//   out_valid  out  out_code / out_sof / out_eol are valid
//   out_ready  in   downstream accepts output
//   out_sof    out  in_sof, delayed to line up with the pixel
//   out_eol    out  in_eol, delayed to line up with the pixel

module vga_color_encoder #(
    parameter int X_BITS = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [23:0] in_color,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_sof,
    input  logic        in_eol,
    output logic [7:0]  out_code,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_sof,
    output logic        out_eol
);

    logic              s1Valid_q;
    logic [23:0]       s1Color_q;
    logic [23:0]       s1Color_d;
    logic              s1Sof_q;
    logic              s1Eol_q;
    logic              outValid_q;
    logic [7:0]        outCode_q;
    logic [7:0]        outCode_d;
    logic              outSof_q;
    logic              outEol_q;
    logic [X_BITS-1:0] x_q;
    logic [X_BITS-1:0] x_d;
    logic [1:0]        y_q;
    logic [1:0]        y_d;
    logic [X_BITS-1:0] pixX;
    logic [1:0]        pixY;
    logic              s1Load;
    logic              s2Load;
    logic              inAccept;

    // Quantizer: the result is the number of thresholds strictly below the value.
    // Each threshold sits midway between adjacent RGB332 expansion levels,
    // so every expanded code maps back to itself.
    function automatic logic [2:0] quantRG(input logic [7:0] v);
        if (v > 8'd237)      return 3'd7;
        else if (v > 8'd200) return 3'd6;
        else if (v > 8'd164) return 3'd5;
        else if (v > 8'd127) return 3'd4;
        else if (v > 8'd91)  return 3'd3;
        else if (v > 8'd54)  return 3'd2;
        else if (v > 8'd18)  return 3'd1;
        else                 return 3'd0;
    endfunction

    function automatic logic [1:0] quantB(input logic [7:0] v);
        if (v > 8'd212)     return 2'd3;
        else if (v > 8'd127) return 2'd2;
        else if (v > 8'd42)  return 2'd1;
        else                 return 2'd0;
    endfunction

`ifdef VGA_COLOR_ENCODER_DITHER_EN
    logic [3:0]         bayerD;
    logic signed [10:0] offRG;
    logic signed [10:0] offB;

    // 4x4 Bayer matrix, indexed by {row, column}.
    function automatic logic [3:0] bayer(input logic [1:0] row, input logic [1:0] col);
        case ({row, col})
            4'd0:  return 4'd0;
            4'd1:  return 4'd8;
            4'd2:  return 4'd2;
            4'd3:  return 4'd10;
            4'd4:  return 4'd12;
            4'd5:  return 4'd4;
            4'd6:  return 4'd14;
            4'd7:  return 4'd6;
            4'd8:  return 4'd3;
            4'd9:  return 4'd11;
            4'd10: return 4'd1;
            4'd11: return 4'd9;
            4'd12: return 4'd15;
            4'd13: return 4'd7;
            4'd14: return 4'd13;
            default: return 4'd5;
        endcase
    endfunction

    function automatic logic [7:0] clampOffset(input logic [7:0] c, input logic signed [10:0] off);
        logic signed [10:0] sum;
        sum = $signed({3'b000, c}) + off;
        if (sum < 0)               return 8'd0;
        else if (sum > 11'sd255)   return 8'd255;
        else                       return sum[7:0];
    endfunction

    // Dither offsets are centred on zero:
    // R and G get 2d-16 (range -16..+14); B gets 5d-40 (range -40..+35).
    always_comb begin
        bayerD    = bayer(pixY, pixX[1:0]);
        offRG     = $signed({6'b000000, bayerD, 1'b0}) - 11'sd16;
        offB      = $signed({7'b0000000, bayerD} + {5'b00000, bayerD, 2'b00}) - 11'sd40;
        s1Color_d = {clampOffset(in_color[23:16], offRG),
                     clampOffset(in_color[15:8], offRG),
                     clampOffset(in_color[7:0], offB)};
    end
`else
    // Without dithering, channels enter S1 unchanged.
    always_comb begin
        s1Color_d = in_color;
    end
`endif

    // Handshake. S2 advances when its slot is free or is being drained.
    // S1 advances when it is empty or is pushing into S2.
    // in_ready depends combinationally on out_ready, so a full pipe can
    // still accept a pixel in the same cycle it drains one.
    always_comb begin
        s2Load   = !outValid_q || out_ready;
        s1Load   = !s1Valid_q || s2Load;
        inAccept = in_valid && s1Load;
    end

    // Pixel coordinates. A start-of-frame pixel is always (0,0),
    // whatever the counters hold. An end-of-line pixel moves to the
    // next row (mod 4); otherwise the column advances.
    always_comb begin
        pixX = in_sof ? '0 : x_q;
        pixY = in_sof ? 2'd0 : y_q;
        x_d  = x_q;
        y_d  = y_q;
        if (inAccept) begin
            if (in_eol) begin
                x_d = '0;
                y_d = pixY + 2'd1;
            end else begin
                x_d = pixX + 1'b1;
                y_d = pixY;
            end
        end
    end

    always_comb begin
        outCode_d = {quantRG(s1Color_q[23:16]), quantRG(s1Color_q[15:8]), quantB(s1Color_q[7:0])};
    end

    // Pipeline registers and coordinate counters.
    // Reset empties both stages, so any pixel still in flight is discarded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1Valid_q  <= 1'b0;
            s1Color_q  <= '0;
            s1Sof_q    <= 1'b0;
            s1Eol_q    <= 1'b0;
            outValid_q <= 1'b0;
            outCode_q  <= '0;
            outSof_q   <= 1'b0;
            outEol_q   <= 1'b0;
            x_q        <= '0;
            y_q        <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
            if (s1Load) begin
                s1Valid_q <= in_valid;
                s1Color_q <= s1Color_d;
                s1Sof_q   <= in_sof;
                s1Eol_q   <= in_eol;
            end
            if (s2Load) begin
                outValid_q <= s1Valid_q;
                outCode_q  <= outCode_d;
                outSof_q   <= s1Sof_q;
                outEol_q   <= s1Eol_q;
            end
        end
    end

    assign in_ready  = s1Load;
    assign out_valid = outValid_q;
    assign out_code  = outCode_q;
    assign out_sof   = outSof_q;
    assign out_eol   = outEol_q;

endmodule

// File: tb/tb_vga_color_encoder.sv
// tb_vga_color_encoder
//
// Directed testbench for vga_color_encoder.
// Expected pixels go into a queue. A negedge monitor compares every
// output transfer against the head of that queue.
// Tests covered: reset state, latency, thresholds, the full code sweep
// (dither off), backpressure, reset mid-burst, and the Bayer frame
// pattern (dither on, with VGA_COLOR_ENCODER_DITHER_EN defined).

`timescale 1ns/1ps

module tb_vga_color_encoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [23:0] inColor;
    logic        inValid;
    logic        inReady;
    logic        inSof;
    logic        inEol;
    logic [7:0]  outCode;
    logic        outValid;
    logic        outReady;
    logic        outSof;
    logic        outEol;

    int          checks = 0;
    int          failures = 0;
    int          cycleCount = 0;
    int          mx = 0;
    int          my = 0;
    logic [9:0]  expQ[$];
    logic [9:0]  expWord;
    logic [23:0] burstColor[10];
    logic [7:0]  burstExp[10];
    int          thrRG[7] = '{18, 54, 91, 127, 164, 200, 237};
    int          thrB[3]  = '{42, 127, 212};
`ifdef VGA_COLOR_ENCODER_DITHER_EN
    int          bayerTb[4][4] = '{'{0, 8, 2, 10}, '{12, 4, 14, 6}, '{3, 11, 1, 9}, '{15, 7, 13, 5}};
`endif

    vga_color_encoder #(.X_BITS(10)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_color  (inColor),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in_sof    (inSof),
        .in_eol    (inEol),
        .out_code  (outCode),
        .out_valid (outValid),
        .out_ready (outReady),
        .out_sof   (outSof),
        .out_eol   (outEol)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycleCount <= cycleCount + 1;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [7:0] exp3(input logic [2:0] v);
        return {v, v, v[2:1]};
    endfunction

`ifdef VGA_COLOR_ENCODER_DITHER_EN
    function automatic int clampTb(input int v);
        if (v < 0)   return 0;
        if (v > 255) return 255;
        return v;
    endfunction
`endif

    // Reference encoder. It also tracks pixel coordinates for dithering.
    // Call it exactly once per pixel, in acceptance order.
    function automatic logic [7:0] modelCode(input logic [23:0] color, input logic sof, input logic eol);
        int px, py, r, g, b, qr, qg, qb;
        px = sof ? 0 : mx;
        py = sof ? 0 : my;
        r = int'(color[23:16]);
        g = int'(color[15:8]);
        b = int'(color[7:0]);
`ifdef VGA_COLOR_ENCODER_DITHER_EN
        r = clampTb(r + 2 * bayerTb[py][px % 4] - 16);
        g = clampTb(g + 2 * bayerTb[py][px % 4] - 16);
        b = clampTb(b + 5 * bayerTb[py][px % 4] - 40);
`endif
        qr = 0; qg = 0; qb = 0;
        foreach (thrRG[i]) begin
            if (thrRG[i] < r) qr++;
            if (thrRG[i] < g) qg++;
        end
        foreach (thrB[i]) if (thrB[i] < b) qb++;
        if (eol) begin
            mx = 0;
            my = (py + 1) % 4;
        end else begin
            mx = (px + 1) % 1024;
            my = py;
        end
        return {3'(qr), 3'(qg), 2'(qb)};
    endfunction

    // Present one pixel and wait, with a bound, until it is accepted.
    // The pixel's expected output is queued just before the accepting edge.
    task automatic applyStimulus(input logic [23:0] color, input logic sof, input logic eol, input logic [7:0] code);
        int waitCycles;
        waitCycles = 0;
        inColor = color;
        inSof   = sof;
        inEol   = eol;
        inValid = 1'b1;
        @(negedge clk);
        while (!inReady && waitCycles < 50) begin
            @(negedge clk);
            waitCycles++;
        end
        if (waitCycles >= 50) checkOutput("accept_timeout", 32'(waitCycles), 32'd0);
        expQ.push_back({sof, eol, code});
        @(posedge clk);
        #1;
        inValid = 1'b0;
        inSof   = 1'b0;
        inEol   = 1'b0;
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while ((expQ.size() != 0 || outValid) && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput("drain_empty", 32'(expQ.size()), 32'd0);
    endtask

    // Output scoreboard. It samples at negedge, away from the active edge.
    always @(negedge clk) begin
        if (!reset && outValid && outReady) begin
            if (expQ.size() == 0) begin
                checkOutput("out_unexpected", {22'd0, outSof, outEol, outCode}, 32'hFFFF_FFFF);
            end else begin
                expWord = expQ.pop_front();
                checkOutput("out_pixel", {22'd0, outSof, outEol, outCode}, {22'd0, expWord});
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [7:0] lc;
        logic [7:0] code;
        int         startCycle;

        reset    = 1'b1;
        inValid  = 1'b0;
        inColor  = '0;
        inSof    = 1'b0;
        inEol    = 1'b0;
        outReady = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_outvalid", 32'(outValid), 32'd0);
        checkOutput("reset_code", 32'(outCode), 32'd0);
        checkOutput("reset_sof", 32'(outSof), 32'd0);
        checkOutput("reset_eol", 32'(outEol), 32'd0);
        checkOutput("reset_inready", 32'(inReady), 32'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Latency: out_valid must be low one cycle after acceptance
        // and high the cycle after that.
        code = modelCode(24'hFF_00_55, 1'b1, 1'b0);
        applyStimulus(24'hFF_00_55, 1'b1, 1'b0, code);
        checkOutput("lat_cycle1_outvalid", 32'(outValid), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("lat_cycle2_outvalid", 32'(outValid), 32'd1);
        checkOutput("lat_code", 32'(outCode), 32'(code));
        waitDrain();

`ifndef VGA_COLOR_ENCODER_DITHER_EN
        // Threshold boundaries, with hand-computed codes.
        applyStimulus({8'd91, 8'd0, 8'd0}, 1'b0, 1'b0, 8'h40);
        applyStimulus({8'd92, 8'd0, 8'd0}, 1'b0, 1'b1, 8'h60);
        applyStimulus({8'd0, 8'd0, 8'd212}, 1'b1, 1'b0, 8'h02);
        applyStimulus({8'd0, 8'd0, 8'd213}, 1'b0, 1'b1, 8'h03);
        waitDrain();

        // Every RGB332 code, expanded, must encode back to itself.
        // This runs back to back, one pixel per cycle.
        startCycle = cycleCount;
        for (int c = 0; c < 256; c++) begin
            lc = 8'(c);
            applyStimulus({exp3(lc[7:5]), exp3(lc[4:2]), {lc[1:0], lc[1:0], lc[1:0], lc[1:0]}},
                          c == 0, lc[3:0] == 4'hF, lc);
        end
        checkOutput("sweep_throughput", 32'(cycleCount - startCycle), 32'd256);
        waitDrain();
`else
        // Constant mid-grey over six 4-pixel rows. Row 4 wraps back to
        // Bayer row 0. Column 0 and column 3 of Bayer row 0 have
        // hand-computed codes.
        for (int row = 0; row < 6; row++) begin
            for (int col = 0; col < 4; col++) begin
                code = modelCode(24'h808080, row == 0 && col == 0, col == 3);
                if (row % 4 == 0 && col == 0) code = 8'h6D;
                if (row % 4 == 0 && col == 3) code = 8'h92;
                applyStimulus(24'h808080, row == 0 && col == 0, col == 3, code);
            end
        end
        // A pixel with both sof and eol set is (0,0); the next pixel
        // is then (0,1), which uses d=12.
        code = modelCode(24'h808080, 1'b1, 1'b1);
        applyStimulus(24'h808080, 1'b1, 1'b1, code);
        void'(modelCode(24'h808080, 1'b0, 1'b0));
        applyStimulus(24'h808080, 1'b0, 1'b0, 8'h92);
        waitDrain();
`endif

        // Backpressure: out_ready drops for 5 cycles during a 10-pixel burst.
        for (int i = 0; i < 10; i++) begin
            burstColor[i] = {8'(i * 25), 8'(255 - i * 20), 8'(i * 13 + 40)};
            burstExp[i]   = modelCode(burstColor[i], 1'b0, i == 9);
        end
        fork
            begin
                for (int i = 0; i < 10; i++) applyStimulus(burstColor[i], 1'b0, i == 9, burstExp[i]);
            end
            begin
                repeat (3) @(posedge clk);
                #1;
                outReady = 1'b0;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk);
                    checkOutput("bp_inready_low", 32'(inReady), 32'd0);
                    checkOutput("bp_hold_valid", 32'(outValid), 32'd1);
                    checkOutput("bp_hold_code", 32'(outCode), 32'(burstExp[1]));
                    @(posedge clk);
                end
                #1;
                outReady = 1'b1;
            end
        join
        waitDrain();

        // Reset while two pixels are in flight. Outputs clear at once,
        // and no stale pixel appears after release.
        code = modelCode(24'h123456, 1'b0, 1'b0);
        applyStimulus(24'h123456, 1'b0, 1'b0, code);
        code = modelCode(24'hABCDEF, 1'b0, 1'b0);
        applyStimulus(24'hABCDEF, 1'b0, 1'b0, code);
        checkOutput("rst_pre_outvalid", 32'(outValid), 32'd1);
        reset = 1'b1;
        #1;
        checkOutput("rst_async_outvalid", 32'(outValid), 32'd0);
        checkOutput("rst_async_code", 32'(outCode), 32'd0);
        checkOutput("rst_inready", 32'(inReady), 32'd1);
        expQ.delete();
        mx = 0;
        my = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checkOutput("rst_no_stale", 32'(outValid), 32'd0);
        end
        @(posedge clk);
        #1;
        void'(modelCode(24'h00FF00, 1'b1, 1'b0));
        applyStimulus(24'h00FF00, 1'b1, 1'b0, 8'h1C);
        waitDrain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
